// File: rtl/rv32i_pkg.sv
// Shared fetch definitions: reset/trap vector defaults, fetch FSM encoding
// and the fetch output bundle.
package rv32i_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } if_out_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if_stage.sv
// PC datapath for the fetch stage: PC+4, next-PC selection and
// instruction-address alignment decode.
module if_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic [31:0] c,
    input  logic        advance,
    input  logic        trap,
    output logic [31:0] pc4,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    assign pc4        = pc + 32'd4;
    assign misaligned = is_misaligned(pc);

    // A redirect beats everything; a trap only fires when no redirect is pending.
    always_comb begin
        next_pc = pc;
        if (jump)
            next_pc = c;
        else if (trap)
            next_pc = TRAP_VEC;
        else if (advance)
            next_pc = pc4;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: issues imem reads at the PC, registers the
// fetched instruction for ID, and handles redirects, drains and misalignment.
module fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] c,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        i_addr_misaligned
);

    fetch_state_e state, state_nxt;
    logic [31:0]  pc, pc4, pc_nxt;
    logic         misaligned, can_issue, take;
    if_out_t      out_q, out_nxt;
    logic         valid_q, valid_nxt;

    if_stage #(.TRAP_VEC(TRAP_VEC)) u_if_stage (
        .pc         (pc),
        .jump       (jump),
        .c          (c),
        .advance    (take),
        .trap       (i_addr_misaligned),
        .pc4        (pc4),
        .next_pc    (pc_nxt),
        .misaligned (misaligned)
    );

    // Only request when the output register can accept the result.
    assign can_issue = !valid_q || !stall;
    assign take      = imem_req && imem_ack && !jump;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = ST_REQ;
            ST_REQ:   if (jump && imem_req && !imem_ack) state_nxt = ST_DRAIN;
            ST_DRAIN: if (imem_ack) state_nxt = ST_REQ;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req          = 1'b0;
        i_addr_misaligned = 1'b0;
        if (state == ST_REQ) begin
            imem_req          = !misaligned && can_issue;
            i_addr_misaligned = misaligned && !jump;
        end
    end

    // Output register: flush on jump, load on ack, otherwise hold while stalled.
    always_comb begin
        out_nxt   = out_q;
        valid_nxt = valid_q && stall;
        if (jump) begin
            valid_nxt = 1'b0;
        end else if (take) begin
            out_nxt.inst = imem_rdata;
            out_nxt.pc   = pc;
            out_nxt.pc4  = pc4;
            valid_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            out_q   <= out_nxt;
            valid_q <= valid_nxt;
        end
    end

    assign if_valid = valid_q;
    assign if_inst  = out_q.inst;
    assign if_pc    = out_q.pc;
    assign if_pc4   = out_q.pc4;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, streaming fetch, stall hold, redirect
// drain, misaligned trap, PC wrap, jump priority and mid-request reset.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] c = '0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_valid;
    logic [31:0] if_inst, if_pc, if_pc4;
    logic        i_addr_misaligned;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I0 = 32'h1111_0013;
    localparam logic [31:0] I1 = 32'h2222_0093;
    localparam logic [31:0] I2 = 32'h3333_0113;
    localparam logic [31:0] BAD = 32'hDEAD_BEEF;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .TRAP_VEC(32'h0000_0100)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .jump              (jump),
        .c                 (c),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .if_valid          (if_valid),
        .if_inst           (if_inst),
        .if_pc             (if_pc),
        .if_pc4            (if_pc4),
        .i_addr_misaligned (i_addr_misaligned)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in REQ at PC=0 with all inputs idle.
    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; jump = 1'b0; imem_ack = 1'b0; c = '0; imem_rdata = '0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; jump = 1'b0; imem_ack = 1'b0;
        step(); step(); #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", if_valid); end
        checks++; if (if_inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h expected 0", if_inst); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", if_pc); end
        checks++; if (if_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h expected 0", if_pc4); end
        checks++; if (i_addr_misaligned !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b expected 0", i_addr_misaligned); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 0", imem_addr); end
        rst = 1'b0; #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", imem_req); end
        step(); #2;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h expected 0", imem_addr); end
    endtask

    task automatic test_sequential();
        do_reset();
        imem_ack = 1'b1; imem_rdata = I0; #2;
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL seq_addr0: got %h expected 0", imem_addr); end
        step(); imem_rdata = I1; #2;
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid0: got %b expected 1", if_valid); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL seq_pc0: got %h expected 0", if_pc); end
        checks++; if (if_pc4 !== 32'h4) begin errors++; $display("FAIL seq_pc4_0: got %h expected 4", if_pc4); end
        checks++; if (if_inst !== I0) begin errors++; $display("FAIL seq_inst0: got %h expected %h", if_inst, I0); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr4: got %h expected 4", imem_addr); end
        step(); imem_rdata = I2; #2;
        checks++; if (if_pc !== 32'h4) begin errors++; $display("FAIL seq_pc4: got %h expected 4", if_pc); end
        checks++; if (if_pc4 !== 32'h8) begin errors++; $display("FAIL seq_pc4_4: got %h expected 8", if_pc4); end
        checks++; if (if_inst !== I1) begin errors++; $display("FAIL seq_inst1: got %h expected %h", if_inst, I1); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL seq_addr8: got %h expected 8", imem_addr); end
        step(); imem_ack = 1'b0; #2;
        checks++; if (if_pc !== 32'h8) begin errors++; $display("FAIL seq_pc8: got %h expected 8", if_pc); end
        checks++; if (if_inst !== I2) begin errors++; $display("FAIL seq_inst2: got %h expected %h", if_inst, I2); end
        checks++; if (imem_addr !== 32'hC) begin errors++; $display("FAIL seq_addrC: got %h expected c", imem_addr); end
        step(); #2;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL seq_consumed: got %b expected 0", if_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        imem_ack = 1'b1; imem_rdata = I0;
        step(); imem_rdata = I1;
        step(); imem_ack = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            #2;
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, if_valid); end
            checks++; if (if_pc !== 32'h4) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected 4", i, if_pc); end
            checks++; if (if_inst !== I1) begin errors++; $display("FAIL stall_inst[%0d]: got %h expected %h", i, if_inst, I1); end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d]: got %b expected 0", i, imem_req); end
        end
        step(); stall = 1'b0; imem_ack = 1'b1; imem_rdata = I2; #2;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL unstall_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL unstall_addr: got %h expected 8", imem_addr); end
        step(); imem_ack = 1'b0; #2;
        checks++; if (if_pc !== 32'h8) begin errors++; $display("FAIL unstall_pc: got %h expected 8", if_pc); end
        checks++; if (if_inst !== I2) begin errors++; $display("FAIL unstall_inst: got %h expected %h", if_inst, I2); end
    endtask

    task automatic test_jump_drain();
        do_reset();
        imem_ack = 1'b1; imem_rdata = I0;
        step(); imem_ack = 1'b0; jump = 1'b1; c = 32'h40; #2;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drain_outstanding: got %b expected 1", imem_req); end
        step(); jump = 1'b0; #2;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL drain_flush: got %b expected 0", if_valid); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_req0: got %b expected 0", imem_req); end
        step(); imem_ack = 1'b1; imem_rdata = BAD; #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL drain_req1: got %b expected 0", imem_req); end
        step(); imem_ack = 1'b0; #2;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL drain_discard: got %b expected 0", if_valid); end
        checks++; if (if_inst !== I0) begin errors++; $display("FAIL drain_inst: got %h expected %h", if_inst, I0); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL drain_resume: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL drain_addr: got %h expected 40", imem_addr); end
    endtask

    task automatic test_misaligned();
        do_reset();
        jump = 1'b1; c = 32'h42; imem_ack = 1'b1; imem_rdata = BAD; #2;
        checks++; if (i_addr_misaligned !== 1'b0) begin errors++; $display("FAIL mis_at_jump: got %b expected 0", i_addr_misaligned); end
        step(); jump = 1'b0; imem_ack = 1'b0; #2;
        checks++; if (i_addr_misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b expected 1", i_addr_misaligned); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b expected 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL mis_valid: got %b expected 0", if_valid); end
        step(); #2;
        checks++; if (i_addr_misaligned !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b expected 0", i_addr_misaligned); end
        checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL mis_trap_addr: got %h expected 100", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mis_trap_req: got %b expected 1", imem_req); end
    endtask

    task automatic test_wrap();
        do_reset();
        jump = 1'b1; c = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = BAD;
        step(); jump = 1'b0; imem_rdata = I1; #2;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
        step(); imem_ack = 1'b0; #2;
        checks++; if (if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc: got %h expected fffffffc", if_pc); end
        checks++; if (if_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4: got %h expected 0", if_pc4); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next: got %h expected 0", imem_addr); end
    endtask

    task automatic test_jump_priority();
        do_reset();
        imem_ack = 1'b1; imem_rdata = I0;
        step(); jump = 1'b1; stall = 1'b1; imem_rdata = BAD; c = 32'h80;
        step(); jump = 1'b0; stall = 1'b0; imem_ack = 1'b0; #2;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL prio_valid: got %b expected 0", if_valid); end
        checks++; if (imem_addr !== 32'h80) begin errors++; $display("FAIL prio_pc: got %h expected 80", imem_addr); end
        checks++; if (if_inst !== I0) begin errors++; $display("FAIL prio_inst: got %h expected %h", if_inst, I0); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL prio_req: got %b expected 1", imem_req); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        #2;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %b expected 1", imem_req); end
        rst = 1'b1;
        step(); rst = 1'b0; imem_ack = 1'b1; imem_rdata = BAD; #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmid_idle: got %b expected 0", imem_req); end
        step(); imem_ack = 1'b0; #2;
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rmid_ignored: got %b expected 0", if_valid); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr: got %h expected 0", imem_addr); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rmid_req: got %b expected 1", imem_req); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jump_drain();
        test_misaligned();
        test_wrap();
        test_jump_priority();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
